pad_sequencer: RTL

//   Block-level controller for the SHA-256 padder. Runs one message of msg_size bytes as N 512-bit blocks.
//   For each block it drives the padder's start/en/offset/cur_block and addresses the message buffer.
//   It streams the 16 padded words to the compression core under a block handshake.

---
 rtl/pad_sequencer_pkg.sv | 15 +
 rtl/pad_blk_calc.sv | 14 +
 rtl/pad_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pad_sequencer_pkg.sv
// pad_sequencer_pkg: shared SHA-256 padding constants and sequencer state encoding
package pad_sequencer_pkg;
    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_BYTES = 64;
    localparam int LEN_BYTES   = 8;
    localparam int CNT_W       = 53;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_BUSYCORE,
        S_FINISH
    } state_t;
endpackage

// File: rtl/pad_blk_calc.sv
// pad_blk_calc: total block count N, data block count D and length-field overflow flag from msg_size
module pad_blk_calc
    import pad_sequencer_pkg::*;
(
    input  logic [63:0]      msg_size,
    output logic [CNT_W-1:0] n_blocks,
    output logic [CNT_W-1:0] d_blocks,
    output logic             tail_ovf
);
    assign n_blocks = CNT_W'((msg_size + 64'(LEN_BYTES)) >> 6) + CNT_W'(1);
    assign d_blocks = CNT_W'((msg_size + 64'(BLOCK_BYTES - 1)) >> 6);
    // the 8-byte length field no longer fits behind the 0x80 marker
    assign tail_ovf = msg_size[5:0] >= 6'(BLOCK_BYTES - LEN_BYTES);
endmodule

// File: rtl/pad_sequencer.sv
// pad_sequencer: block-level controller that streams padded 512-bit blocks to the SHA-256 core
module pad_sequencer
    import pad_sequencer_pkg::*;
#(
    parameter int NUM_BLOCKS = 2,
    parameter int ADDR_WIDTH = $clog2(NUM_BLOCKS) + 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [63:0]           msg_size,
    input  logic                  src_valid,
    input  logic                  core_ready,
    input  logic                  core_done,
    input  logic                  pad_of,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  pad_start,
    output logic                  pad_en,
    output logic [3:0]            pad_offset,
    output logic [52:0]           pad_cur_block,
    output logic                  word_valid,
    output logic [3:0]            word_idx,
    output logic                  slot_free,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] d_q, d_d;
    logic             tail_q, tail_d;
    logic [3:0]       off_q, off_d;
    logic             err_q, err_d;
    logic             word_valid_q, word_valid_d;
    logic [3:0]       word_idx_q, word_idx_d;
    logic [CNT_W-1:0] n_calc, d_calc;
    logic             tail_calc;
    logic             last_blk, pen_blk;

    pad_blk_calc u_calc (
        .msg_size (msg_size),
        .n_blocks (n_calc),
        .d_blocks (d_calc),
        .tail_ovf (tail_calc)
    );

    assign last_blk = blk_cnt_q == n_q - CNT_W'(1);
    assign pen_blk  = tail_q && n_q >= CNT_W'(2) && blk_cnt_q == n_q - CNT_W'(2);

    always_comb begin
        state_d       = state_q;
        blk_cnt_d     = blk_cnt_q;
        n_d           = n_q;
        d_d           = d_q;
        tail_d        = tail_q;
        off_d         = off_q;
        err_d         = err_q;
        pad_en        = 1'b0;
        pad_start     = 1'b0;
        pad_offset    = 4'd0;
        pad_cur_block = 53'd0;
        slot_free     = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                n_d       = n_calc;
                d_d       = d_calc;
                tail_d    = tail_calc;
                blk_cnt_d = '0;
                err_d     = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: if (core_ready && (src_valid || blk_cnt_q >= d_q)) begin
                off_d   = 4'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                pad_en        = 1'b1;
                pad_start     = off_q == 4'd0;
                pad_offset    = off_q;
                pad_cur_block = blk_cnt_q;
                off_d         = off_q + 4'd1;
                state_d       = off_q == 4'(BLOCK_WORDS - 1) ? S_DRAIN : S_ISSUE;
            end
            S_DRAIN: begin
                // word 15 is on the padder output now, so its overflow flag is valid
                err_d   = err_q | core_done | (pad_of && last_blk) | (!pad_of && pen_blk);
                state_d = S_BUSYCORE;
            end
            S_BUSYCORE: if (core_done) begin
                slot_free = blk_cnt_q < d_q;
                blk_cnt_d = blk_cnt_q + CNT_W'(1);
                state_d   = last_blk ? S_FINISH : S_WAIT;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        word_valid_d = pad_en;
        word_idx_d   = pad_offset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            blk_cnt_q    <= '0;
            n_q          <= '0;
            d_q          <= '0;
            tail_q       <= 1'b0;
            off_q        <= 4'd0;
            err_q        <= 1'b0;
            word_valid_q <= 1'b0;
            word_idx_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            blk_cnt_q    <= blk_cnt_d;
            n_q          <= n_d;
            d_q          <= d_d;
            tail_q       <= tail_d;
            off_q        <= off_d;
            err_q        <= err_d;
            word_valid_q <= word_valid_d;
            word_idx_q   <= word_idx_d;
        end
    end

    assign mem_addr   = {blk_cnt_q[ADDR_WIDTH-5:0], off_q};
    assign word_valid = word_valid_q;
    assign word_idx   = word_idx_q;
    assign busy       = state_q != S_IDLE;
    assign err        = err_q;
endmodule
